fios_res_collector: RTL and testbench
=====================================

Name: fios_res_collector

Overview:
- Downstream stage of the FIOS Montgomery multiplier.
- Captures the word-serial 17-bit result stream (RES_o, LSW first) into a parallel s-word register.
- Applies the final conditional subtraction of the modulus p: the FIOS output lies in [0, 2p), and the subtraction brings it into [0, p).
- Presents the reduced result to the consumer over a valid/ready handshake.

Parameters:
- s, 8: number of 17-bit words per operand/result.
- W, 17: word width; fixed at 17 to match the DSP datapath.
- CNT_W, $clog2(s+1): word counter width (derived, not overridden).

Ports:
- clock_i  in  1  single system clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- p_i  in  s*17  modulus, word k at [k*17+:17]; must be stable from first word until result accepted.
- res_word_i  in  17  result word from multiplier RES_o.
- res_valid_i  in  1  qualifies res_word_i; one pulse per word, s pulses per result, LSW first, gaps allowed.
- result_o  out  s*17  reduced result, word k at [k*17+:17].
- result_valid_o  out  1  result_o holds a complete result.
- result_ready_i  in  1  consumer accepts result when high with result_valid_o.
- busy_o  out  1  high while a result is being collected (COLLECT state).
- overflow_o  out  1  sticky: a word arrived in HOLD and was dropped.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, word counter=0, borrow=0, result_o=0, result_valid_o=0, busy_o=0, overflow_o=0, both word buffers cleared.
- States:
  - IDLE: counter=0. res_valid_i -> store word 0, go to COLLECT. If s==1, go directly to HOLD.
  - COLLECT: each res_valid_i stores word k and increments the counter. When k==s-1 is stored -> HOLD next cycle. No res_valid_i -> stay.
  - HOLD: result_valid_o=1. result_valid_o & result_ready_i -> IDLE. If res_valid_i arrives in the same cycle, that word is NOT captured: it is dropped and overflow_o is set.
- Per accepted word k:
  - raw[k] <= res_word_i.
  - {b, diff[k]} <= {1'b0, res_word_i} - {1'b0, p_i[k*17+:17]} - borrow_in, 18-bit arithmetic.
  - borrow_in = 0 for k==0, else the registered borrow from word k-1.
  - Borrow is registered; it is reset to 0 when entering IDLE.
- Final select, on the transition into HOLD:
  - final borrow==0 (raw >= p): result_o <= diff.
  - final borrow==1: result_o <= raw.
- Latency: result_valid_o rises exactly one cycle after the cycle carrying the s-th res_valid_i.
- result_o is stable throughout HOLD; it holds its last value (not cleared) in IDLE/COLLECT.
- raw == p exactly: borrow=0, output all zeros.
- Back-to-back results: the first word of the next result may arrive in the cycle after acceptance (IDLE).
  - A word arriving in the acceptance cycle is dropped and overflow_o is set.
  - The multiplier controller must guarantee at least one cycle of gap.
- overflow_o is cleared only by reset.
- Reset asserted mid-COLLECT or mid-HOLD: partial words and the pending result are discarded immediately, and all outputs return to reset values.
- busy_o = (state==COLLECT).

Optional Feature:
- Macro: FIOS_FINAL_SUB_EN.
- Defined: conditional subtraction as above; subtractor and diff buffer instantiated.
- Undefined: no subtraction logic; result_o <= raw words unmodified, i.e. a value in [0, 2p). Latency and handshake are unchanged.

Test Plan:
- s=2, p=0x00001_00011 (words 0x00011, 0x00001); send raw words 0x00005, 0x00000 -> raw<p, result_o=0x00000_00005, result_valid_o one cycle after 2nd word.
- s=2, same p; raw words 0x00020, 0x00001 -> raw>=p, result_o=0x00000_0000F (borrow-free path). Also raw words 0x00000, 0x00002 -> result_o=0x00000_1FFEF, exercising the inter-word borrow.
- s=2, raw==p (0x00011, 0x00001) -> result_o=0, result_valid_o=1.
- Hold result_ready_i=0 for 5 cycles, then pulse res_valid_i -> result_o unchanged, overflow_o=1 and stays 1. Then ready=1 -> valid drops next cycle, state IDLE.
- Assert reset_n_i=0 after first word of a 2-word result -> outputs 0 asynchronously. After release, a full new result collects correctly starting from word 0.
- Build without FIOS_FINAL_SUB_EN; raw 0x00020, 0x00001 with p above -> result_o=0x00001_00020. Same latency.

Source files
------------

// File: rtl/fios_res_collector.sv
// Collects the word-serial FIOS result (LSW first), optionally applies the final
// conditional subtraction of p (macro FIOS_FINAL_SUB_EN), and hands it off via valid/ready.
module fios_res_collector #(
  parameter int s = 8,
  parameter int W = 17
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic [s*W-1:0]   p_i,
  input  logic [W-1:0]     res_word_i,
  input  logic             res_valid_i,
  output logic [s*W-1:0]   result_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             busy_o,
  output logic             overflow_o
);

  localparam int CNT_W = $clog2(s + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_HOLD} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [s*W-1:0]   r_raw;
  logic [s*W-1:0]   w_raw_next;
  logic [s*W-1:0]   w_final;
  logic             w_accept;
  logic             w_last;

  assign w_accept = res_valid_i && (r_state != ST_HOLD);
  assign w_last   = (r_cnt == CNT_W'(s - 1));

  // Raw buffer as it will look once the current word lands, so the final
  // select can be made in the same cycle as the last word.
  generate
    for (genvar gi = 0; gi < s; gi++) begin : g_raw
      assign w_raw_next[gi*W +: W] = (w_accept && (r_cnt == CNT_W'(gi))) ?
                                     res_word_i : r_raw[gi*W +: W];
    end
  endgenerate

`ifdef FIOS_FINAL_SUB_EN
  logic             r_borrow;
  logic [s*W-1:0]   r_diff;
  logic [s*W-1:0]   w_diff_next;
  logic [W-1:0]     w_p_word;
  logic             w_borrow_in;
  logic [W:0]       w_sub;

  always_comb begin
    w_p_word = '0;
    for (int k = 0; k < s; k++) begin
      if (r_cnt == CNT_W'(k)) w_p_word = p_i[k*W +: W];
    end
  end

  assign w_borrow_in = (r_cnt == '0) ? 1'b0 : r_borrow;
  assign w_sub = {1'b0, res_word_i} - {1'b0, w_p_word} - {{W{1'b0}}, w_borrow_in};

  generate
    for (genvar gi = 0; gi < s; gi++) begin : g_diff
      assign w_diff_next[gi*W +: W] = (w_accept && (r_cnt == CNT_W'(gi))) ?
                                      w_sub[W-1:0] : r_diff[gi*W +: W];
    end
  endgenerate

  // Final borrow set means raw < p, so the unreduced value is already in range.
  assign w_final = w_sub[W] ? w_raw_next : w_diff_next;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_borrow <= 1'b0;
      r_diff   <= '0;
    end else if (w_accept) begin
      r_borrow <= w_sub[W];
      r_diff   <= w_diff_next;
    end else if ((r_state == ST_HOLD) && result_ready_i) begin
      r_borrow <= 1'b0;
    end
  end
`else
  logic w_unused_p;
  assign w_unused_p = ^p_i;
  assign w_final    = w_raw_next;
`endif

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_raw          <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      overflow_o     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_COLLECT: begin
          if (res_valid_i) begin
            r_raw <= w_raw_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state        <= ST_HOLD;
              result_o       <= w_final;
              result_valid_o <= 1'b1;
              busy_o         <= 1'b0;
            end else begin
              r_state <= ST_COLLECT;
              busy_o  <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (res_valid_i) overflow_o <= 1'b1;
          if (result_ready_i) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            result_valid_o <= 1'b0;
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_cnt          <= '0;
          result_valid_o <= 1'b0;
          busy_o         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fios_res_collector.sv
// Scoreboard bench for fios_res_collector with s=2; expected results are
// hand-computed for both builds of FIOS_FINAL_SUB_EN.
module tb_fios_res_collector;

  localparam int S = 2;
  localparam int W = 17;

`ifdef FIOS_FINAL_SUB_EN
  localparam logic [33:0] E1 = {17'h00000, 17'h00005};
  localparam logic [33:0] E2 = {17'h00000, 17'h0000F};
  localparam logic [33:0] E3 = {17'h00000, 17'h1FFEF};
  localparam logic [33:0] E4 = {17'h00000, 17'h00000};
`else
  localparam logic [33:0] E1 = {17'h00000, 17'h00005};
  localparam logic [33:0] E2 = {17'h00001, 17'h00020};
  localparam logic [33:0] E3 = {17'h00002, 17'h00000};
  localparam logic [33:0] E4 = {17'h00001, 17'h00011};
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [S*W-1:0]  p;
  logic [W-1:0]    res_word;
  logic            res_valid;
  logic [S*W-1:0]  result;
  logic            result_valid;
  logic            result_ready;
  logic            busy;
  logic            overflow;

  int n_vec = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];

  fios_res_collector #(.s(S), .W(W)) dut (
    .clock_i        (clk),
    .reset_n_i      (rst_n),
    .p_i            (p),
    .res_word_i     (res_word),
    .res_valid_i    (res_valid),
    .result_o       (result),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .busy_o         (busy),
    .overflow_o     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h at %0t", name, act, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one two-word result; the expected value is queued with the last word.
  task automatic send(input logic [16:0] w0, input logic [16:0] w1,
                      input int gap, input logic [33:0] exp);
    res_word = w0; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    repeat (gap) step();
    chk("pre_latency_valid", {63'd0, result_valid}, 64'd0);
    chk("busy_collect", {63'd0, busy}, 64'd1);
    exp_q.push_back(exp);
    res_word = w1; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    chk("latency_valid", {63'd0, result_valid}, 64'd1);
  endtask

  task automatic send_accept(input logic [16:0] w0, input logic [16:0] w1,
                             input int gap, input logic [33:0] exp);
    send(w0, w1, gap, exp);
    step();
    chk("valid_after_accept", {63'd0, result_valid}, 64'd0);
  endtask

  // Monitor: pop and compare on every handshake.
  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got %h expected none at %0t", result, $time);
      end else begin
        chk("result", {30'd0, result}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    p = {17'h00001, 17'h00011};
    rst_n = 1'b0; res_word = '0; res_valid = 1'b0; result_ready = 1'b1;
    repeat (2) step();
    chk("rst_result", {30'd0, result}, 64'd0);
    chk("rst_valid", {63'd0, result_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    rst_n = 1'b1;
    step();

    send_accept(17'h00005, 17'h00000, 0, E1);
    send_accept(17'h00020, 17'h00001, 2, E2);
    send_accept(17'h00000, 17'h00002, 1, E3);
    send_accept(17'h00011, 17'h00001, 0, E4);

    // Stall in HOLD, then a stray word must be dropped and flagged.
    result_ready = 1'b0;
    send(17'h00020, 17'h00001, 0, E2);
    repeat (5) step();
    chk("hold_valid", {63'd0, result_valid}, 64'd1);
    chk("hold_stable", {30'd0, result}, {30'd0, E2});
    res_word = 17'h1ABCD; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    chk("overflow_set", {63'd0, overflow}, 64'd1);
    chk("hold_after_drop", {30'd0, result}, {30'd0, E2});
    step();
    chk("overflow_sticky", {63'd0, overflow}, 64'd1);
    result_ready = 1'b1;
    step();
    chk("valid_after_accept", {63'd0, result_valid}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("overflow_kept", {63'd0, overflow}, 64'd1);
    send_accept(17'h00005, 17'h00000, 0, E1);

    // Reset mid-collect: outputs clear asynchronously, partial word discarded.
    res_word = 17'h00007; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    chk("busy_partial", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_overflow", {63'd0, overflow}, 64'd0);
    chk("arst_result", {30'd0, result}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    send_accept(17'h00020, 17'h00001, 0, E2);

    // Reset mid-hold: pending result is discarded.
    result_ready = 1'b0;
    send(17'h00000, 17'h00002, 0, E3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hold_valid", {63'd0, result_valid}, 64'd0);
    chk("arst_hold_result", {30'd0, result}, 64'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    result_ready = 1'b1;
    step();
    send_accept(17'h00011, 17'h00001, 1, E4);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
